// File: rtl/lattice_pkg.sv
// Shared definitions for the lattice dot-matrix scan engine.
//   mode_e     : display modes (static, scroll/marquee, blink); encoding 3 is
//                reserved and decoded as static.
//   decode_mode: maps the raw 2-bit mode request onto mode_e.
//   row_level  : drive level of one row-select pin, honouring row polarity.
package lattice_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_SCROLL = 2'd1,
        MODE_BLINK  = 2'd2
    } mode_e;

    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return MODE_SCROLL;
            2'd2:    return MODE_BLINK;
            default: return MODE_STATIC;
        endcase
    endfunction

    // One bit of the active-row one-hot: row r is selected when r == idx.
    // With active_low set, the selected row reads 0 and all others read 1.
    function automatic logic row_level(input int unsigned r,
                                       input int unsigned idx,
                                       input logic        active_low);
        return (r == idx) ^ active_low;
    endfunction

endpackage

// File: rtl/lattice_pattern_ram.sv
// Glyph storage: NPAT patterns of ROWS rows, COLS bits per row (bit c = column
// c lit). Flop array, not reset; contents are undefined until written.
//   clk_2               : write clock
//   wr_en/wr_pat/wr_row : write strobe and address; out-of-range addresses
//                         are dropped
//   wr_data             : row bits to store
//   rd_pat_a/rd_pat_b   : pattern index of the two combinational read ports
//   rd_row              : row index shared by both read ports
//   rd_data_a/rd_data_b : row bits read from each port
module lattice_pattern_ram #(
    parameter int unsigned NPAT = 5,
    parameter int unsigned ROWS = 8,
    parameter int unsigned COLS = 8
) (
    input  logic                    clk_2,
    input  logic                    wr_en,
    input  logic [$clog2(NPAT)-1:0] wr_pat,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic [$clog2(NPAT)-1:0] rd_pat_a,
    input  logic [$clog2(NPAT)-1:0] rd_pat_b,
    input  logic [$clog2(ROWS)-1:0] rd_row,
    output logic [COLS-1:0]         rd_data_a,
    output logic [COLS-1:0]         rd_data_b
);

    logic [COLS-1:0] mem [NPAT][ROWS];

    always_ff @(posedge clk_2) begin
        if (wr_en && (32'(wr_pat) < NPAT) && (32'(wr_row) < ROWS)) begin
            mem[wr_pat][wr_row] <= wr_data;
        end
    end

    assign rd_data_a = mem[rd_pat_a][rd_row];
    assign rd_data_b = mem[rd_pat_b][rd_row];

endmodule

// File: rtl/lattice_scan_engine.sv
// Row-multiplexed driver for a ROWS x COLS dot-matrix display.
// Each row is shown for SCAN_DIV cycles; mode and pattern selection only
// change at frame boundaries so a frame never mixes two glyph states.
//   clk_2      : scan clock
//   rst        : asynchronous active-high reset
//   mode       : requested mode (0 static, 1 scroll, 2 blink, 3 = static)
//   sel        : requested pattern, out-of-range values select pattern 0
//   wr_en/wr_pat/wr_row/wr_data : pattern write port, visible immediately
//   row        : row select pins (polarity set by ROW_ACTIVE_LOW)
//   col        : column data, 1 = lit
//   frame_done : high during the cycle whose edge ends the frame
//   cur_pat    : pattern currently on display (left part while scrolling)
module lattice_scan_engine
    import lattice_pkg::*;
#(
    parameter int unsigned NPAT           = 5,
    parameter int unsigned ROWS           = 8,
    parameter int unsigned COLS           = 8,
    parameter int unsigned SCAN_DIV       = 4,
    parameter int unsigned STEP_FRAMES    = 2,
    parameter bit          ROW_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk_2,
    input  logic                    rst,
    input  logic [1:0]              mode,
    input  logic [$clog2(NPAT)-1:0] sel,
    input  logic                    wr_en,
    input  logic [$clog2(NPAT)-1:0] wr_pat,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    output logic [ROWS-1:0]         row,
    output logic [COLS-1:0]         col,
    output logic                    frame_done,
    output logic [$clog2(NPAT)-1:0] cur_pat
);

    localparam int unsigned SW  = $clog2(NPAT);
    localparam int unsigned RW  = $clog2(ROWS);
    localparam int unsigned OW  = $clog2(COLS);
    localparam int unsigned PSW = $clog2(SCAN_DIV);
    localparam int unsigned FW  = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int unsigned XW  = $clog2(2 * COLS);

    logic [PSW-1:0] presc, presc_n;
    logic [RW-1:0]  ridx, ridx_n;
    logic [FW-1:0]  fcnt, fcnt_n;
    logic [OW-1:0]  off, off_n;
    logic           blank, blank_n;
    logic [SW-1:0]  cur, cur_n;
    mode_e          mode_q, mode_n;

    logic           row_tick, boundary, step_tick;
    mode_e          mode_req;
    logic [SW-1:0]  sel_ok, nxt;
    logic [COLS-1:0] cur_data, nxt_data;
    logic [2*COLS-1:0] pair;
    logic [ROWS-1:0] row_d;
    logic [COLS-1:0] col_d;

    lattice_pattern_ram #(
        .NPAT (NPAT),
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_ram (
        .clk_2     (clk_2),
        .wr_en     (wr_en),
        .wr_pat    (wr_pat),
        .wr_row    (wr_row),
        .wr_data   (wr_data),
        .rd_pat_a  (cur),
        .rd_pat_b  (nxt),
        .rd_row    (ridx),
        .rd_data_a (cur_data),
        .rd_data_b (nxt_data)
    );

    assign row_tick   = (presc == PSW'(SCAN_DIV - 1));
    assign boundary   = row_tick && (ridx == RW'(ROWS - 1));
    assign step_tick  = boundary && (fcnt == FW'(STEP_FRAMES - 1));
    assign frame_done = boundary;

    assign mode_req = decode_mode(mode);
    assign sel_ok   = (32'(sel) < NPAT) ? sel : '0;
    assign nxt      = (cur == SW'(NPAT - 1)) ? '0 : cur + 1'b1;

    // Next-state: counters always run; display state moves only at boundaries.
    always_comb begin
        presc_n = presc + 1'b1;
        ridx_n  = ridx;
        fcnt_n  = fcnt;
        off_n   = off;
        blank_n = blank;
        cur_n   = cur;
        mode_n  = mode_q;

        if (row_tick) begin
            presc_n = '0;
            ridx_n  = (ridx == RW'(ROWS - 1)) ? '0 : ridx + 1'b1;
        end

        if (boundary) begin
            mode_n = mode_req;
            fcnt_n = (fcnt == FW'(STEP_FRAMES - 1)) ? '0 : fcnt + 1'b1;
            if (mode_req != mode_q) begin
                // A mode change restarts scroll/blink; cur carries into scroll.
                off_n   = '0;
                blank_n = 1'b0;
                if (mode_req != MODE_SCROLL) begin
                    cur_n = sel_ok;
                end
            end else begin
                case (mode_q)
                    MODE_SCROLL: begin
                        if (step_tick) begin
                            if (off == OW'(COLS - 1)) begin
                                off_n = '0;
                                cur_n = nxt;
                            end else begin
                                off_n = off + 1'b1;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        cur_n = sel_ok;
                        if (step_tick) begin
                            blank_n = ~blank;
                        end
                    end
                    default: begin
                        cur_n = sel_ok;
                    end
                endcase
            end
        end
    end

    // Column c shows bit c+off of {next pattern, current pattern}.
    assign pair = {nxt_data, cur_data};

    always_comb begin
        row_d = '0;
        col_d = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            row_d[r] = row_level(r, 32'(ridx), ROW_ACTIVE_LOW);
        end
        for (int unsigned c = 0; c < COLS; c++) begin
            col_d[c] = pair[XW'(c) + XW'(off)];
        end
        if (blank) begin
            col_d = '0;
        end
    end

    always_ff @(posedge clk_2 or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            ridx    <= '0;
            fcnt    <= '0;
            off     <= '0;
            blank   <= 1'b0;
            cur     <= '0;
            mode_q  <= MODE_STATIC;
            row     <= {ROWS{ROW_ACTIVE_LOW}};
            col     <= '0;
            cur_pat <= '0;
        end else begin
            presc   <= presc_n;
            ridx    <= ridx_n;
            fcnt    <= fcnt_n;
            off     <= off_n;
            blank   <= blank_n;
            cur     <= cur_n;
            mode_q  <= mode_n;
            row     <= row_d;
            col     <= col_d;
            cur_pat <= cur;
        end
    end

endmodule
